ifetch: RTL and testbench

Instruction fetch stage that owns the program counter, issues word addresses to the instruction port of `cache`, and captures returned instruction words into a small FIFO that feeds decode/`exe` through a valid/ready handshake. It sits directly upstream of execute. It takes redirects (`jmp_en`/`jmp_addr`) from `exe`, squashing all buffered and in-flight fetches on each redirect.

---
 rtl/ifetch.sv | 122 ++++++++++++
 tb/tb_ifetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues word addresses to the
// instruction cache, and buffers returned words in a small FIFO that feeds
// decode/execute through a valid/ready handshake. Redirects from execute
// squash every buffered and in-flight fetch.
// Optional feature macro: IFETCH_MISALIGN_EN. When it is defined, a redirect
// to a non-word-aligned target halts fetch and raises fetch_err until reset.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] i_addr,
  input  logic [31:0] ins,
  input  logic        jmp_en,
  input  logic [31:0] jmp_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   pend_pc;
  logic          pend;
  entry_t        fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          run;
  logic          pop;
  logic          push;
  logic          issue;
  logic          misalign;
  logic [CW:0]   occ;

  assign run = (state == RUN);

  // A pop is lost to a redirect: the consumer drops its own copy on jmp_en.
  assign pop  = inst_valid & inst_ready & ~jmp_en;
  assign push = pend & ~jmp_en & run;

  // Credit: buffered + in-flight entries after this cycle's pop must leave room,
  // so a returning word always finds a free slot.
  assign occ   = {1'b0, count} + (CW+1)'(pend) - (CW+1)'(pop);
  assign issue = run & ~jmp_en & (occ < (CW+1)'(FIFO_DEPTH));

`ifdef IFETCH_MISALIGN_EN
  assign misalign  = |jmp_addr[1:0];
  assign fetch_err = (state == HALT);
`else
  assign misalign  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign i_addr     = pc;
  assign inst_valid = (count != '0);
  // Head fields are forced to zero while empty so reset shows clean outputs.
  assign inst       = inst_valid ? fifo[rd_ptr].word : 32'h0;
  assign inst_pc    = inst_valid ? fifo[rd_ptr].pc   : 32'h0;

  // Instruction buffer storage: capture the returning word with its address.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo[wr_ptr] <= '{word: ins, pc: pend_pc};
  end

  // Fetch control FSM: PC, in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 32'h0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (jmp_en) begin
            // Squash everything buffered and the word still coming back.
            pend   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (misalign) state <= HALT;
            else          pc    <= jmp_addr & 32'hFFFF_FFFC;
          end else begin
            pend <= issue;
            if (issue) begin
              pc      <= pc + 32'd4;
              pend_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
          end
        end
        HALT: begin
          // Dead until reset: nothing issued, buffer kept empty.
          pend   <= 1'b0;
          count  <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios followed by randomized ready/redirect/
// reset traffic. Expected delivery order is kept as a queue of program-order
// addresses per fetch stream; a negedge monitor compares every handshake.
module tb_ifetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_addr;
  logic [31:0] ins = 32'h0;
  logic        jmp_en = 1'b0;
  logic [31:0] jmp_addr = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic        fetch_err;

  ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .ins(ins),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Cache model: one-cycle read, word content derived from its address.
  always @(posedge clk) ins <= i_addr ^ KEY;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected program-order addresses of the live stream.
  logic [31:0] q[$];
  logic [31:0] nxt;
  logic [31:0] start_pc;
  int          age       = 0;
  bit          started   = 0;
  bit          halted    = 0;
  bit          prev_rst  = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;

  task automatic new_stream(input logic [31:0] s);
    q.delete();
    start_pc = s;
    nxt      = s;
    for (int k = 0; k < 8; k++) begin
      q.push_back(nxt);
      nxt += 32'd4;
    end
    age = 0;
  endtask

  // Monitor: checks outputs mid-cycle, then applies this cycle's events.
  always @(negedge clk) begin
    logic        acc;
    logic [31:0] exp_pc;
    if (started) begin
      if (prev_rst) begin
        chk("rst_i_addr",  i_addr,            RESET_PC);
        chk("rst_valid",   32'(inst_valid),   32'd0);
        chk("rst_inst",    inst,              32'd0);
        chk("rst_inst_pc", inst_pc,           32'd0);
        chk("rst_err",     32'(fetch_err),    32'd0);
      end
      if (!rst) begin
        age++;
        if (halted) begin
          chk("halt_valid", 32'(inst_valid), 32'd0);
          chk("halt_err",   32'(fetch_err),  32'd1);
        end else begin
          chk("err_low", 32'(fetch_err), 32'd0);
          if (age == 1) chk("start_i_addr", i_addr, start_pc);
          if (age <= 2) chk("bubble_valid", 32'(inst_valid), 32'd0);
          else          chk("stream_valid", 32'(inst_valid), 32'd1);
          if (prev_hold) begin
            chk("hold_pc",   inst_pc, prev_pc);
            chk("hold_inst", inst,    prev_inst);
          end
          if (inst_valid) chk("inst_word", inst, inst_pc ^ KEY);
          if (q.size() > 0)
            chk("credit", 32'((i_addr - q[0]) <= 32'(4 * DEPTH)), 32'd1);
          acc = inst_valid & inst_ready & ~jmp_en;
          if (acc) begin
            if (q.size() == 0) begin
              chk("deliver_nonempty", 32'd0, 32'd1);
            end else begin
              exp_pc = q.pop_front();
              chk("deliver_pc", inst_pc, exp_pc);
              q.push_back(nxt);
              nxt += 32'd4;
            end
          end
        end
      end
    end
    if (rst) begin
      started = 1;
      halted  = 0;
      new_stream(RESET_PC);
    end else if (started && jmp_en && !halted) begin
`ifdef IFETCH_MISALIGN_EN
      if (jmp_addr[1:0] != 2'b00) begin
        halted = 1;
        q.delete();
      end else begin
        new_stream(jmp_addr & 32'hFFFF_FFFC);
      end
`else
      new_stream(jmp_addr & 32'hFFFF_FFFC);
`endif
    end
    prev_rst  = rst;
    prev_hold = started && !rst && !jmp_en && !halted && inst_valid && !inst_ready;
    prev_pc   = inst_pc;
    prev_inst = inst;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic jump(input logic [31:0] a);
    jmp_en   = 1'b1;
    jmp_addr = a;
    step(1);
    jmp_en   = 1'b0;
  endtask

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    rst = 1'b1; inst_ready = 1'b1; jmp_en = 1'b0; jmp_addr = 32'h0;
    step(2);
    rst = 1'b0;
    step(2);
    // Stall from the first valid cycle: buffer fills, fetch address freezes.
    inst_ready = 1'b0;
    step(6);
    chk("stall_i_addr", i_addr, 32'h8);
    inst_ready = 1'b1;
    step(6);
    // Redirect while stalled with a full buffer.
    inst_ready = 1'b0;
    step(4);
    jump(32'h100);
    inst_ready = 1'b1;
    step(6);
    // Redirect while streaming (one buffered, one in flight).
    jump(32'h40);
    step(6);
    // Address wrap past the top of memory.
    jump(32'hFFFF_FFF8);
    step(8);
    // Misaligned target.
    jump(32'h102);
`ifdef IFETCH_MISALIGN_EN
    step(3);
    jump(32'h200);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
`else
    step(6);
`endif
    // Single-cycle reset in the middle of a stream.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(3) != 0);
      rst        = ($urandom_range(199) == 0);
      jmp_en     = ($urandom_range(15) == 0);
      jmp_addr   = $urandom;
`ifdef IFETCH_MISALIGN_EN
      jmp_addr[1:0] = 2'b00;
`endif
      step(1);
    end
    rst = 1'b0;
    jmp_en = 1'b0;
    inst_ready = 1'b1;
    step(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
